// File: rtl/div_arbiter_if.sv
// One requester's request/response channel to the shared divider arbiter.
// master = requester side, slave = arbiter side.
interface div_arbiter_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_signed;
  logic [31:0]          req_dividend;
  logic [31:0]          req_divisor;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_quotient;
  logic [31:0]          resp_remainder;
  logic [TAG_WIDTH-1:0] resp_tag;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_tag
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor, req_tag, resp_ready,
    output req_ready, resp_valid, resp_quotient, resp_remainder, resp_tag
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one multi-cycle divider between two requesters, one result buffer each.
// Optional macro DIV_ZERO_BYPASS_EN answers divide-by-zero locally without launching the divider.
module div_arbiter #(
  parameter int TAG_WIDTH = 4,
  parameter bit RR_INIT   = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  div_arbiter_if.slave port0,
  div_arbiter_if.slave port1,
  output logic         div_op_div,
  output logic         div_op_divu,
  output logic [31:0]  div_dividend,
  output logic [31:0]  div_divisor,
  input  logic [31:0]  div_quotient,
  input  logic [31:0]  div_remainder,
  input  logic         div_stall,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, BUSY} state_t;

  state_t               state_q, state_d;
  logic                 prio_q;
  logic                 owner_q;
  logic                 zero_pend_q;
  logic [31:0]          dividend_q;
  logic [31:0]          divisor_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [1:0]           rvalid_q;
  logic [31:0]          rquot_q [2];
  logic [31:0]          rrem_q  [2];
  logic [TAG_WIDTH-1:0] rtag_q  [2];

  logic                 elig0, elig1, grant0, grant1, accept, capture;
  logic                 sel_signed, sel_zero;
  logic [31:0]          sel_dividend, sel_divisor;
  logic [TAG_WIDTH-1:0] sel_tag;

  always_comb begin
    state_d      = state_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    sel_zero     = 1'b0;
    elig0        = port0.req_valid & ~rvalid_q[0];
    elig1        = port1.req_valid & ~rvalid_q[1];
    sel_signed   = port0.req_signed;
    sel_dividend = port0.req_dividend;
    sel_divisor  = port0.req_divisor;
    sel_tag      = port0.req_tag;
    case (state_q)
      IDLE: begin
        // A pending zero-divide write occupies the operand latches for one cycle.
        if (!flush && !zero_pend_q) begin
          if (elig0 && (!elig1 || !prio_q)) grant0 = 1'b1;
          else if (elig1)                   grant1 = 1'b1;
        end
      end
      LAUNCH:  state_d = WAIT;
      WAIT:    state_d = BUSY;
      BUSY:    if (!div_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    accept = grant0 | grant1;
    if (grant1) begin
      sel_signed   = port1.req_signed;
      sel_dividend = port1.req_dividend;
      sel_divisor  = port1.req_divisor;
      sel_tag      = port1.req_tag;
    end
`ifdef DIV_ZERO_BYPASS_EN
    sel_zero = (sel_divisor == 32'd0);
`endif
    if (accept && !sel_zero) state_d = LAUNCH;
    capture = (state_q == BUSY) && !div_stall && !flush;
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q      <= RR_INIT;
      owner_q     <= 1'b0;
      zero_pend_q <= 1'b0;
      div_op_div  <= 1'b0;
      div_op_divu <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      tag_q       <= '0;
      rvalid_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        rquot_q[i] <= '0;
        rrem_q[i]  <= '0;
        rtag_q[i]  <= '0;
      end
    end else begin
      div_op_div  <= 1'b0;
      div_op_divu <= 1'b0;
      zero_pend_q <= 1'b0;
      if (port0.resp_ready) rvalid_q[0] <= 1'b0;
      if (port1.resp_ready) rvalid_q[1] <= 1'b0;
      if (accept) begin
        dividend_q <= sel_dividend;
        divisor_q  <= sel_divisor;
        tag_q      <= sel_tag;
        owner_q    <= grant1;
        prio_q     <= grant0;
        if (sel_zero) zero_pend_q <= 1'b1;
        else begin
          div_op_div  <= sel_signed;
          div_op_divu <= ~sel_signed;
        end
      end
      // The owner's buffer is always empty while its op is in flight, so capture never races a clear.
      if (capture) begin
        rvalid_q[owner_q] <= 1'b1;
        rquot_q[owner_q]  <= div_quotient;
        rrem_q[owner_q]   <= div_remainder;
        rtag_q[owner_q]   <= tag_q;
      end
      if (zero_pend_q && !flush) begin
        rvalid_q[owner_q] <= 1'b1;
        rquot_q[owner_q]  <= 32'hFFFF_FFFF;
        rrem_q[owner_q]   <= dividend_q;
        rtag_q[owner_q]   <= tag_q;
      end
    end
  end

  assign port0.req_ready      = grant0;
  assign port1.req_ready      = grant1;
  assign port0.resp_valid     = rvalid_q[0];
  assign port1.resp_valid     = rvalid_q[1];
  assign port0.resp_quotient  = rquot_q[0];
  assign port1.resp_quotient  = rquot_q[1];
  assign port0.resp_remainder = rrem_q[0];
  assign port1.resp_remainder = rrem_q[1];
  assign port0.resp_tag       = rtag_q[0];
  assign port1.resp_tag       = rtag_q[1];
  assign div_dividend         = dividend_q;
  assign div_divisor          = divisor_q;
  assign busy                 = (state_q != IDLE);
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural 32-cycle Divide model on the divider side.
module tb_div_arbiter;
  localparam int TW = 4;

  typedef struct {
    logic [31:0]   q;
    logic [31:0]   r;
    logic [TW-1:0] tag;
    int            lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush;
  logic        div_op_div, div_op_divu, div_stall, busy;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;

  div_arbiter_if #(.TAG_WIDTH(TW)) p0 ();
  div_arbiter_if #(.TAG_WIDTH(TW)) p1 ();

  div_arbiter #(.TAG_WIDTH(TW), .RR_INIT(1'b0)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .port0(p0.slave), .port1(p1.slave),
    .div_op_div(div_op_div), .div_op_divu(div_op_divu),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_stall(div_stall), .busy(busy)
  );

  always #5 clock = ~clock;

  // Divide model: stall high for 32 cycles after the op edge, result valid once stall drops.
  function automatic logic [63:0] model_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sg)         return {32'(sa / sb), 32'(sa % sb)};
    return {a / b, a % b};
  endfunction

  logic [63:0] mres;
  logic [63:0] pend_res;
  logic [5:0]  dcnt;
  logic        dact;
  always_comb mres = model_div(div_op_div, div_dividend, div_divisor);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dact <= 1'b0; dcnt <= '0; pend_res <= '0; div_quotient <= '0; div_remainder <= '0;
    end else if (div_op_div || div_op_divu) begin
      dact <= 1'b1; dcnt <= 6'd31; pend_res <= mres;
    end else if (dact) begin
      if (dcnt == 6'd0) begin
        dact <= 1'b0; div_quotient <= pend_res[63:32]; div_remainder <= pend_res[31:0];
      end else dcnt <= dcnt - 6'd1;
    end
  end
  assign div_stall = dact;

  int   ncmp = 0, nfail = 0;
  int   cyc = 0, n_div = 0, n_divu = 0, n_grant = 0;
  int   acc_cnt [2] = '{0, 0};
  int   acc_cyc [2] = '{0, 0};
  int   grant_log [16];
  exp_t sb0 [$];
  exp_t sb1 [$];
  logic pv0 = 1'b0, pv1 = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (div_op_div)  n_div  <= n_div + 1;
    if (div_op_divu) n_divu <= n_divu + 1;
    if (p0.req_valid && p0.req_ready) begin
      acc_cnt[0] <= acc_cnt[0] + 1; acc_cyc[0] <= cyc + 1;
      if (n_grant < 16) grant_log[n_grant] <= 0;
      n_grant <= n_grant + 1;
    end
    if (p1.req_valid && p1.req_ready) begin
      acc_cnt[1] <= acc_cnt[1] + 1; acc_cyc[1] <= cyc + 1;
      if (n_grant < 16) grant_log[n_grant] <= 1;
      n_grant <= n_grant + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, expv);
    end
  endtask

  task automatic check_resp(input int n, input logic [31:0] q, input logic [31:0] r, input logic [TW-1:0] tg);
    exp_t e;
    bit   have;
    have = (n == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
    if (!have) begin
      ncmp++; nfail++;
      $display("FAIL resp%0d_unexpected: got q=%h r=%h tag=%h, required no response", n, q, r, tg);
      return;
    end
    if (n == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    check($sformatf("resp%0d_quotient", n), q, e.q);
    check($sformatf("resp%0d_remainder", n), r, e.r);
    check($sformatf("resp%0d_tag", n), 32'(tg), 32'(e.tag));
    check($sformatf("resp%0d_latency", n), 32'(cyc - acc_cyc[n]), 32'(e.lat));
  endtask

  always @(negedge clock) begin
    if (p0.resp_valid && !pv0) check_resp(0, p0.resp_quotient, p0.resp_remainder, p0.resp_tag);
    if (p1.resp_valid && !pv1) check_resp(1, p1.resp_quotient, p1.resp_remainder, p1.resp_tag);
    pv0 <= p0.resp_valid;
    pv1 <= p1.resp_valid;
  end

  task automatic drive(input int n, input logic v, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] tg);
    if (n == 0) begin
      p0.req_valid = v; p0.req_signed = sg; p0.req_dividend = a; p0.req_divisor = b; p0.req_tag = tg;
    end else begin
      p1.req_valid = v; p1.req_signed = sg; p1.req_dividend = a; p1.req_divisor = b; p1.req_tag = tg;
    end
  endtask

  task automatic push_exp(input int n, input logic [31:0] q, input logic [31:0] r,
                          input logic [TW-1:0] tg, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.tag = tg; e.lat = lat;
    if (n == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic issue(input int n, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tg, input bit want, input logic [31:0] eq,
                       input logic [31:0] er, input int lat);
    int start;
    bit got;
    if (want) push_exp(n, eq, er, tg, lat);
    start = acc_cnt[n];
    got   = 1'b0;
    drive(n, 1'b1, sg, a, b, tg);
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clock); #1;
      got = (acc_cnt[n] != start);
    end
    drive(n, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    if (!got) begin
      ncmp++; nfail++;
      $display("FAIL accept%0d: got no accept in 100 cycles, required accept", n);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int d_div, d_divu, gexp;
    flush = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    p0.resp_ready = 1'b1;
    p1.resp_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_div", 32'(div_op_div), 32'd0);
    check("rst_op_divu", 32'(div_op_divu), 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_resp0_valid", 32'(p0.resp_valid), 32'd0);
    check("rst_resp1_valid", 32'(p1.resp_valid), 32'd0);
    check("rst_resp0_quotient", p0.resp_quotient, 32'd0);
    #19 reset = 1'b0;
    idle_cycles(1);

    // Unsigned 100/7
    d_div = n_div; d_divu = n_divu;
    issue(0, 1'b0, 32'd100, 32'd7, 4'd3, 1'b1, 32'd14, 32'd2, 34);
    idle_cycles(40);
    check("t1_divu_pulses", 32'(n_divu - d_divu), 32'd1);
    check("t1_div_pulses", 32'(n_div - d_div), 32'd0);
    check("t1_dividend_held", div_dividend, 32'd100);
    check("t1_divisor_held", div_divisor, 32'd7);

    // Signed -100/7: truncating division, remainder takes the dividend's sign
    d_div = n_div; d_divu = n_divu;
    issue(0, 1'b1, 32'hFFFF_FF9C, 32'd7, 4'd5, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34);
    idle_cycles(40);
    check("t2_div_pulses", 32'(n_div - d_div), 32'd1);
    check("t2_divu_pulses", 32'(n_divu - d_divu), 32'd0);

    // Round robin from RR_INIT, then a held resp1 buffer blocks only requester 1
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    idle_cycles(1);
    n_grant = 0;
    push_exp(0, 32'd6, 32'd2, 4'd1, 34);
    push_exp(0, 32'd6, 32'd2, 4'd1, 34);
    push_exp(1, 32'd11, 32'd1, 4'd2, 34);
    push_exp(1, 32'd11, 32'd1, 4'd2, 34);
    drive(0, 1'b1, 1'b0, 32'd20, 32'd3, 4'd1);
    drive(1, 1'b1, 1'b0, 32'd45, 32'd4, 4'd2);
    for (int k = 0; k < 400 && n_grant < 4; k++) idle_cycles(1);
    p1.resp_ready = 1'b0;
    push_exp(0, 32'd6, 32'd2, 4'd1, 34);
    push_exp(0, 32'd6, 32'd2, 4'd1, 34);
    for (int k = 0; k < 400 && n_grant < 6; k++) idle_cycles(1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    check("t3_grant_count", 32'(n_grant), 32'd6);
    for (int i = 0; i < 6; i++) begin
      gexp = (i == 1 || i == 3) ? 1 : 0;
      check($sformatf("t3_grant%0d", i), (i < n_grant) ? 32'(grant_log[i]) : 32'hFF, 32'(gexp));
    end
    idle_cycles(40);
    check("t3_resp1_held", 32'(p1.resp_valid), 32'd1);
    p1.resp_ready = 1'b1;
    idle_cycles(1);
    check("t3_resp1_consumed", 32'(p1.resp_valid), 32'd0);

    // Flush 10 cycles into BUSY abandons the op
    issue(0, 1'b0, 32'd1000, 32'd10, 4'd7, 1'b0, 32'd0, 32'd0, 0);
    idle_cycles(12);
    check("t4_busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    idle_cycles(1);
    flush = 1'b0;
    check("t4_idle_after_flush", 32'(busy), 32'd0);
    idle_cycles(40);
    check("t4_no_resp0", 32'(p0.resp_valid), 32'd0);
    drive(1, 1'b1, 1'b0, 32'd81, 32'd9, 4'd4);
    flush = 1'b1;
    #1;
    check("t4_no_accept_on_flush", 32'(p1.req_ready), 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    flush = 1'b0;
    idle_cycles(1);
    issue(0, 1'b0, 32'd50, 32'd5, 4'd9, 1'b1, 32'd10, 32'd0, 34);
    idle_cycles(40);

    // Asynchronous reset mid-BUSY
    issue(1, 1'b0, 32'd81, 32'd9, 4'd4, 1'b0, 32'd0, 32'd0, 0);
    idle_cycles(12);
    #2 reset = 1'b1;
    #1;
    check("t5_busy_async", 32'(busy), 32'd0);
    check("t5_dividend_async", div_dividend, 32'd0);
    check("t5_divisor_async", div_divisor, 32'd0);
    check("t5_resp1_async", 32'(p1.resp_valid), 32'd0);
    #2 reset = 1'b0;
    idle_cycles(40);
    check("t5_no_resp1", 32'(p1.resp_valid), 32'd0);
    issue(1, 1'b1, 32'd81, 32'hFFFF_FFF7, 4'hA, 1'b1, 32'hFFFF_FFF7, 32'd0, 34);
    idle_cycles(40);

    // Divide by zero on requester 1
    d_div = n_div; d_divu = n_divu;
`ifdef DIV_ZERO_BYPASS_EN
    issue(1, 1'b0, 32'd77, 32'd0, 4'd6, 1'b1, 32'hFFFF_FFFF, 32'd77, 1);
    idle_cycles(40);
    check("t6_op_pulses", 32'((n_div - d_div) + (n_divu - d_divu)), 32'd0);
`else
    issue(1, 1'b0, 32'd77, 32'd0, 4'd6, 1'b1, 32'hFFFF_FFFF, 32'd77, 34);
    idle_cycles(40);
    check("t6_op_pulses", 32'((n_div - d_div) + (n_divu - d_divu)), 32'd1);
`endif

    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
